// File: rtl/irig_pkg.sv
// Shared IRIG-B definitions: frame geometry, BCD field positions, pulse/state
// encodings and the field extraction helper used by the frame packer.
package irig_pkg;

    localparam int FRAME_W   = 164;
    localparam int BITS_W    = 100;
    localparam int SYNC_W    = 64;
    localparam int OUT_WORDS = 5;
    localparam int SEQ_W     = 14;
    localparam int WIDX_W    = 3;

    // Bit positions within the 100-bit frame; each field is LSB-first
    localparam int IRIG_SEC_U_LSB  = 1;
    localparam int IRIG_SEC_T_LSB  = 6;
    localparam int IRIG_MIN_U_LSB  = 10;
    localparam int IRIG_MIN_T_LSB  = 15;
    localparam int IRIG_HR_U_LSB   = 20;
    localparam int IRIG_HR_T_LSB   = 25;
    localparam int IRIG_DAY_U_LSB  = 30;
    localparam int IRIG_DAY_T_LSB  = 35;
    localparam int IRIG_DAY_H_LSB  = 40;
    localparam int IRIG_YR_U_LSB   = 50;
    localparam int IRIG_YR_T_LSB   = 55;
    localparam int IRIG_CF_LO_LSB  = 60;
    localparam int IRIG_CF_HI_LSB  = 70;
    localparam int IRIG_SBS_LO_LSB = 80;
    localparam int IRIG_SBS_HI_LSB = 90;

    typedef enum logic [1:0] {
        PULSE_ZERO = 2'b00,
        PULSE_ONE  = 2'b01,
        PULSE_MARK = 2'b10,
        PULSE_ERR  = 2'b11
    } irig_pulse_t;

    typedef enum logic [1:0] {
        PK_IDLE = 2'b00,
        PK_SEND = 2'b01
    } irig_pk_state_t;

    typedef struct packed {
        logic [3:0] sec_u;
        logic [2:0] sec_t;
        logic [3:0] min_u;
        logic [2:0] min_t;
        logic [3:0] hr_u;
        logic [1:0] hr_t;
        logic [3:0] day_u;
        logic [3:0] day_t;
        logic [1:0] day_h;
        logic [3:0] yr_u;
        logic [3:0] yr_t;
    } irig_digits_t;

    typedef struct packed {
        irig_digits_t digits;
        logic [17:0]  cf;
        logic [16:0]  sbs;
    } irig_fields_t;

    function automatic irig_fields_t irig_extract(input logic [BITS_W-1:0] b);
        irig_fields_t f;
        f.digits.sec_u = b[IRIG_SEC_U_LSB +: 4];
        f.digits.sec_t = b[IRIG_SEC_T_LSB +: 3];
        f.digits.min_u = b[IRIG_MIN_U_LSB +: 4];
        f.digits.min_t = b[IRIG_MIN_T_LSB +: 3];
        f.digits.hr_u  = b[IRIG_HR_U_LSB +: 4];
        f.digits.hr_t  = b[IRIG_HR_T_LSB +: 2];
        f.digits.day_u = b[IRIG_DAY_U_LSB +: 4];
        f.digits.day_t = b[IRIG_DAY_T_LSB +: 4];
        f.digits.day_h = b[IRIG_DAY_H_LSB +: 2];
        f.digits.yr_u  = b[IRIG_YR_U_LSB +: 4];
        f.digits.yr_t  = b[IRIG_YR_T_LSB +: 4];
        f.cf           = {b[IRIG_CF_HI_LSB +: 9], b[IRIG_CF_LO_LSB +: 9]};
        f.sbs          = {b[IRIG_SBS_HI_LSB +: 8], b[IRIG_SBS_LO_LSB +: 9]};
        return f;
    endfunction

endpackage

// File: rtl/irig_bcd_check.sv
// Combinational plausibility check of the decoded BCD time digits.
module irig_bcd_check
    import irig_pkg::*;
(
    input  irig_digits_t digits,
    output logic         bcd_err
);

    logic [5:0] hours_s;
    logic [9:0] day_s;
    logic       digit_err_s;
    logic       range_err_s;

    // Binary hours/day values plus per-digit and range violations
    always_comb begin
        hours_s = 6'(digits.hr_t) * 6'd10 + 6'(digits.hr_u);
        day_s   = 10'(digits.day_h) * 10'd100 + 10'(digits.day_t) * 10'd10
                + 10'(digits.day_u);

        digit_err_s = (digits.sec_u > 4'd9) || (digits.min_u > 4'd9) ||
                      (digits.hr_u  > 4'd9) || (digits.day_u > 4'd9) ||
                      (digits.day_t > 4'd9) || (digits.yr_u  > 4'd9) ||
                      (digits.yr_t  > 4'd9);

        range_err_s = (digits.sec_t > 3'd5) || (digits.min_t > 3'd5) ||
                      (hours_s > 6'd23) || (day_s == 10'd0) ||
                      (day_s > 10'd366);

        bcd_err = digit_err_s || range_err_s;
    end

endmodule

// File: rtl/irig_frame_packer.sv
// Repacks one decoded IRIG-B frame into five 32-bit AXI-Stream words and
// counts frames offered while a previous frame is still being sent.
module irig_frame_packer
    import irig_pkg::*;
#(
    parameter int DROP_W = 16
) (
    input  logic                clk_50MHz,
    input  logic                resetn,
    input  logic [FRAME_W-1:0]  s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tlast,
    output logic [DROP_W-1:0]   drop_count
);

    localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(OUT_WORDS - 1);

    irig_pk_state_t      state_r;
    logic [WIDX_W-1:0]   widx_r;
    logic [SYNC_W-1:0]   sync_r;
    irig_fields_t        fields_r;
    logic                bcd_err_r;
    logic [SEQ_W-1:0]    seq_r;

    logic [SYNC_W-1:0]   sync_in_s;
    irig_fields_t        fields_in_s;
    logic                bcd_err_s;
    logic [SEQ_W-1:0]    seq_nxt_s;
    logic                unused_s;

    assign sync_in_s   = s_axis_tdata[FRAME_W-1:BITS_W];
    assign fields_in_s = irig_extract(s_axis_tdata[BITS_W-1:0]);
    assign seq_nxt_s   = seq_r + SEQ_W'(1);
    // Position-marker bits and tlast carry nothing the packer needs
    assign unused_s    = ^{1'b0, s_axis_tlast, s_axis_tdata};

    // Validation runs on the incoming frame so the flag is captured with it
    irig_bcd_check u_bcd_check (
        .digits  (fields_in_s.digits),
        .bcd_err (bcd_err_s)
    );

    function automatic logic [31:0] pack_word(
        input logic [WIDX_W-1:0] idx,
        input logic [SYNC_W-1:0] sync,
        input irig_fields_t      f,
        input logic              err,
        input logic [SEQ_W-1:0]  seq
    );
        logic [31:0] w;
        case (idx)
            3'd0:    w = sync[31:0];
            3'd1:    w = sync[63:32];
            3'd2:    w = {err, 1'b0,
                          f.digits.day_h, f.digits.day_t, f.digits.day_u,
                          f.digits.hr_t, f.digits.hr_u,
                          f.digits.min_t, f.digits.min_u,
                          f.digits.sec_t, f.digits.sec_u};
            3'd3:    w = {7'd0, f.sbs, f.digits.yr_t, f.digits.yr_u};
            3'd4:    w = {seq, f.cf};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    // Packer FSM: capture on accept, then step through the five output words
    always_ff @(posedge clk_50MHz) begin
        if (!resetn) begin
            state_r       <= PK_IDLE;
            widx_r        <= {WIDX_W{1'b0}};
            sync_r        <= {SYNC_W{1'b0}};
            fields_r      <= '0;
            bcd_err_r     <= 1'b0;
            seq_r         <= {SEQ_W{1'b0}};
            s_axis_tready <= 1'b1;
            m_axis_tdata  <= 32'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state_r)
                PK_IDLE: begin
                    if (s_axis_tvalid && s_axis_tready) begin
                        state_r       <= PK_SEND;
                        widx_r        <= {WIDX_W{1'b0}};
                        sync_r        <= sync_in_s;
                        fields_r      <= fields_in_s;
                        bcd_err_r     <= bcd_err_s;
                        seq_r         <= seq_nxt_s;
                        s_axis_tready <= 1'b0;
                        m_axis_tdata  <= pack_word(3'd0, sync_in_s, fields_in_s,
                                                   bcd_err_s, seq_nxt_s);
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                    end
                end
                PK_SEND: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (widx_r == LAST_WIDX) begin
                            state_r       <= PK_IDLE;
                            s_axis_tready <= 1'b1;
                            m_axis_tdata  <= 32'd0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end else begin
                            widx_r       <= widx_r + 3'd1;
                            m_axis_tdata <= pack_word(widx_r + 3'd1, sync_r, fields_r,
                                                      bcd_err_r, seq_r);
                            m_axis_tlast <= (widx_r == (LAST_WIDX - 3'd1));
                        end
                    end
                end
                default: begin
                    state_r       <= PK_IDLE;
                    widx_r        <= {WIDX_W{1'b0}};
                    s_axis_tready <= 1'b1;
                    m_axis_tdata  <= 32'd0;
                    m_axis_tvalid <= 1'b0;
                    m_axis_tlast  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of frames offered while busy
    always_ff @(posedge clk_50MHz) begin
        if (!resetn) begin
            drop_count <= {DROP_W{1'b0}};
        end else if (s_axis_tvalid && !s_axis_tready &&
                     (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_irig_frame_packer.sv
// Directed self-checking bench for irig_frame_packer with hand-computed words.
module tb_irig_frame_packer;

    localparam int DROP_W = 16;

    logic               clk_50MHz = 1'b0;
    logic               resetn;
    logic [163:0]       s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic               s_axis_tlast;
    logic [31:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tlast;
    logic [DROP_W-1:0]  drop_count;

    int checks = 0;
    int errors = 0;

    irig_frame_packer #(.DROP_W(DROP_W)) dut (
        .clk_50MHz     (clk_50MHz),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .drop_count    (drop_count)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic step();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    // Build frame bits from BCD time values (sec 0xSS, min 0xMM, hr 0xHH, day 0xDDD, yr 0xYY)
    function automatic logic [99:0] mk(input logic [7:0] sec, input logic [7:0] mn,
                                       input logic [7:0] hr, input logic [11:0] day,
                                       input logic [7:0] yr, input logic [17:0] cf,
                                       input logic [16:0] sbs);
        logic [99:0] b;
        b = 100'd0;
        b[4:1]   = sec[3:0];  b[8:6]   = sec[6:4];
        b[13:10] = mn[3:0];   b[17:15] = mn[6:4];
        b[23:20] = hr[3:0];   b[26:25] = hr[5:4];
        b[33:30] = day[3:0];  b[38:35] = day[7:4]; b[41:40] = day[9:8];
        b[53:50] = yr[3:0];   b[58:55] = yr[7:4];
        b[68:60] = cf[8:0];   b[78:70] = cf[17:9];
        b[88:80] = sbs[8:0];  b[97:90] = sbs[16:9];
        return b;
    endfunction

    // Offer one frame with tready high and check all five words cycle by cycle
    task automatic run_frame(input string tag, input logic [63:0] sync, input logic [99:0] bits,
                             input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4);
        logic [31:0] exp_w [5];
        exp_w[0] = sync[31:0];
        exp_w[1] = sync[63:32];
        exp_w[2] = e2;
        exp_w[3] = e3;
        exp_w[4] = e4;
        s_axis_tdata  = {sync, bits};
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        check({tag, ".s_tready_busy"}, 32'(s_axis_tready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s.w%0d", tag, i), m_axis_tdata, exp_w[i]);
            check($sformatf("%s.valid%0d", tag, i), 32'(m_axis_tvalid), 32'd1);
            check($sformatf("%s.last%0d", tag, i), 32'(m_axis_tlast), (i == 4) ? 32'd1 : 32'd0);
            step();
        end
        check({tag, ".valid_done"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, ".s_tready_done"}, 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        logic [99:0] bits1;
        logic [99:0] markers;
        resetn        = 1'b0;
        s_axis_tdata  = 164'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        step(); step(); step();

        check("rst.m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst.m_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst.m_tdata", m_axis_tdata, 32'd0);
        check("rst.s_tready", 32'(s_axis_tready), 32'd1);
        check("rst.drop", 32'(drop_count), 32'd0);
        resetn = 1'b1;
        step();

        // Unused marker/index bits set to ensure they never leak into words
        markers = 100'd0;
        markers[0] = 1'b1;  markers[5] = 1'b1;  markers[9] = 1'b1;  markers[14] = 1'b1;
        markers[19] = 1'b1; markers[24] = 1'b1; markers[29] = 1'b1; markers[34] = 1'b1;
        markers[39] = 1'b1; markers[49] = 1'b1; markers[54] = 1'b1; markers[59] = 1'b1;
        markers[69] = 1'b1; markers[79] = 1'b1; markers[89] = 1'b1; markers[99] = 1'b1;
        bits1 = mk(8'h56, 8'h34, 8'h12, 12'h123, 8'h24, 18'h12345, 17'h1ABCD) | markers;

        run_frame("t1", 64'h0000_0001_0000_00AB, bits1, 32'h12349A56, 32'h01ABCD24, 32'h00052345);
        run_frame("sec65", 64'h1122_3344_5566_7788,
                  mk(8'h65, 8'h34, 8'h12, 12'h123, 8'h24, 18'd0, 17'd0),
                  32'h92349A65, 32'h00000024, 32'h00080000);
        run_frame("day0", 64'h0000_0000_0000_0003,
                  mk(8'h56, 8'h34, 8'h12, 12'h000, 8'h24, 18'd0, 17'd0),
                  32'h80049A56, 32'h00000024, 32'h000C0000);
        // Consecutive frames six cycles apart: day 366 valid, day 367 flagged
        run_frame("d366", 64'h0000_0000_0000_0004,
                  mk(8'h59, 8'h59, 8'h23, 12'h366, 8'h99, 18'd0, 17'd0),
                  32'h3668ECD9, 32'h00000099, 32'h00100000);
        run_frame("d367", 64'h0000_0000_0000_0005,
                  mk(8'h59, 8'h59, 8'h23, 12'h367, 8'h99, 18'd0, 17'd0),
                  32'hB678ECD9, 32'h00000099, 32'h00140000);
        check("b2b.drop", 32'(drop_count), 32'd0);

        // Stall at w2 for 10 cycles with a dropped frame in the middle
        s_axis_tdata  = {64'hDEAD_BEEF_CAFE_F00D, bits1};
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        check("stall.w0", m_axis_tdata, 32'hCAFEF00D);
        step();
        check("stall.w1", m_axis_tdata, 32'hDEADBEEF);
        step();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) s_axis_tvalid = 1'b1;
            step();
            s_axis_tvalid = 1'b0;
            check($sformatf("stall.w2_%0d", i), m_axis_tdata, 32'h12349A56);
            check($sformatf("stall.valid_%0d", i), 32'(m_axis_tvalid), 32'd1);
            check($sformatf("stall.s_tready_%0d", i), 32'(s_axis_tready), 32'd0);
        end
        check("stall.drop", 32'(drop_count), 32'd1);
        m_axis_tready = 1'b1;
        step();
        check("stall.w3", m_axis_tdata, 32'h01ABCD24);
        step();
        check("stall.w4", m_axis_tdata, 32'h00192345);
        check("stall.last", 32'(m_axis_tlast), 32'd1);
        step();
        check("stall.s_tready_done", 32'(s_axis_tready), 32'd1);

        // Reset while w3 is valid
        s_axis_tdata  = {64'h0000_0000_0000_0007, bits1};
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        step(); step(); step();
        check("mid.w3", m_axis_tdata, 32'h01ABCD24);
        resetn = 1'b0;
        step();
        check("mid.m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid.m_tlast", 32'(m_axis_tlast), 32'd0);
        check("mid.m_tdata", m_axis_tdata, 32'd0);
        check("mid.s_tready", 32'(s_axis_tready), 32'd1);
        check("mid.drop", 32'(drop_count), 32'd0);
        resetn = 1'b1;
        run_frame("postrst", 64'h0000_0001_0000_00AB, bits1, 32'h12349A56, 32'h01ABCD24, 32'h00052345);

        // Drop counter saturation
        s_axis_tdata  = {64'h0000_0000_0000_0009, bits1};
        s_axis_tvalid = 1'b1;
        step();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 65534; i++) step();
        check("sat.fffe", 32'(drop_count), 32'h0000FFFE);
        step();
        check("sat.ffff", 32'(drop_count), 32'h0000FFFF);
        step();
        check("sat.hold", 32'(drop_count), 32'h0000FFFF);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("sat.s_tready_done", 32'(s_axis_tready), 32'd1);
        check("sat.drop_kept", 32'(drop_count), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
